spi_pwm_bank: RTL and testbench

SPI_PWM_BANK -- requirements
Module: spi_pwm_bank

---
 rtl/spi_pwm_pkg.sv | 23 ++
 rtl/spi_pwm_slave.sv | 147 ++++++++++++++
 rtl/spi_pwm_bank.sv | 102 ++++++++++
 tb/tb_spi_pwm_bank.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI-controlled PWM bank.
// Holds the command byte layout, the two fixed register addresses,
// the synchroniser depth and the SPI frame-state encoding.
package spi_pwm_pkg;

   // Command byte: bit7 = write(1)/read(0), bits[5:0] = register address
   localparam int CMD_W      = 8;
   localparam int CMD_WR_BIT = 7;
   localparam int ADDR_W     = 6;

   localparam logic [ADDR_W-1:0] ADDR_PERIOD = 6'h3E;
   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 6'h3F;

   localparam int SYNC_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      DONE
   } frame_state_e;

endpackage

// File: rtl/spi_pwm_slave.sv
// SPI mode-0 slave for the PWM bank register file.
// Frame: 8-bit command byte, then PW data bits, both MSB first.
//   clk, reset : system clock, synchronous active-high reset
//   sclk_i     : SPI clock (asynchronous, synchronised here)
//   cs_n_i     : SPI chip select, active-low (asynchronous)
//   mosi_i     : SPI data in
//   rdata_i    : read data for addr_o, combinational from the register file
//   miso_o     : SPI data out, registered
//   wr_en_o    : one-cycle write strobe, valid with addr_o/wdata_o
//   addr_o     : register address from the command byte
//   wdata_o    : write data
module spi_pwm_slave
   import spi_pwm_pkg::*;
#(
   parameter int PW = 8
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                sclk_i,
   input  logic                cs_n_i,
   input  logic                mosi_i,
   input  logic [PW-1:0]       rdata_i,
   output logic                miso_o,
   output logic                wr_en_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic [PW-1:0]       wdata_o
);

   logic [SYNC_DEPTH-1:0] sclk_sync_q;
   logic [SYNC_DEPTH-1:0] cs_sync_q;
   logic [SYNC_DEPTH-1:0] mosi_sync_q;
   logic                  sclk_prev_q;
   logic                  sclk_s, cs_s, mosi_s;
   logic                  sclk_rise, sclk_fall;

   frame_state_e          state_q;
   logic [4:0]            bit_cnt_q;
   logic [CMD_W-1:0]      cmd_q;
   logic [PW-1:0]         rx_q;
   logic [PW-1:0]         tx_q;
   logic                  loaded_q;
   logic                  miso_q;
   logic                  wr_en_q;

   assign sclk_s    = sclk_sync_q[SYNC_DEPTH-1];
   assign cs_s      = cs_sync_q[SYNC_DEPTH-1];
   assign mosi_s    = mosi_sync_q[SYNC_DEPTH-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;

   // The chip-select chain resets to "selected" so that a frame already in
   // progress when reset drops is never mistaken for a fresh cs_n fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_DEPTH-2:0], sclk_i};
         cs_sync_q   <= {cs_sync_q[SYNC_DEPTH-2:0], cs_n_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_DEPTH-2:0], mosi_i};
         sclk_prev_q <= sclk_s;
      end
   end

   // Reset parks the FSM in DONE: a new frame needs cs_n seen high (IDLE)
   // and then low again.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= DONE;
         bit_cnt_q <= '0;
         cmd_q     <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         loaded_q  <= 1'b0;
         miso_q    <= 1'b0;
         wr_en_q   <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         if (cs_s) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            loaded_q  <= 1'b0;
            miso_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q   <= CMD;
                  bit_cnt_q <= '0;
                  loaded_q  <= 1'b0;
               end
               CMD: begin
                  if (sclk_rise) begin
                     cmd_q <= {cmd_q[CMD_W-2:0], mosi_s};
                     if (bit_cnt_q == 5'(CMD_W-1)) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               DATA: begin
                  // First falling edge after the command byte loads the
                  // read word; a write shifts out zeros instead.
                  if (sclk_fall) begin
                     if (!loaded_q) begin
                        loaded_q <= 1'b1;
                        if (cmd_q[CMD_WR_BIT]) begin
                           miso_q <= 1'b0;
                           tx_q   <= '0;
                        end else begin
                           miso_q <= rdata_i[PW-1];
                           tx_q   <= {rdata_i[PW-2:0], 1'b0};
                        end
                     end else begin
                        miso_q <= tx_q[PW-1];
                        tx_q   <= {tx_q[PW-2:0], 1'b0};
                     end
                  end
                  if (sclk_rise) begin
                     rx_q <= {rx_q[PW-2:0], mosi_s};
                     if (bit_cnt_q == 5'(PW-1)) begin
                        state_q <= DONE;
                        wr_en_q <= cmd_q[CMD_WR_BIT];
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               DONE: begin
                  if (sclk_fall) miso_q <= 1'b0;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign miso_o  = miso_q;
   assign wr_en_o = wr_en_q;
   assign addr_o  = cmd_q[ADDR_W-1:0];
   assign wdata_o = rx_q;

endmodule

// File: rtl/spi_pwm_bank.sv
// Bank of NCH PWM channels with double-buffered levels and period,
// configured over SPI. Shadow registers are written over SPI; a commit
// request copies them into the active set at the next counter wrap.
//   clk, reset : system clock, synchronous active-high reset
//   sclk, cs_n, mosi : SPI mode-0 slave inputs (asynchronous)
//   miso       : SPI data out, registered
//   pwm_out    : per-channel PWM outputs, registered
module spi_pwm_bank
   import spi_pwm_pkg::*;
#(
   parameter int NCH = 8,
   parameter int PW  = 8
)
(
   input  logic           clk,
   input  logic           reset,
   input  logic           sclk,
   input  logic           cs_n,
   input  logic           mosi,
   output logic           miso,
   output logic [NCH-1:0] pwm_out
);

   localparam logic [PW-1:0] PER_RST = {{(PW-1){1'b1}}, 1'b0};

   logic              wr_en;
   logic [ADDR_W-1:0] addr;
   logic [PW-1:0]     wdata;
   logic [PW-1:0]     rdata;

   logic [PW-1:0]     shd_lvl_q [NCH];
   logic [PW-1:0]     act_lvl_q [NCH];
   logic [PW-1:0]     shd_per_q, act_per_q;
   logic [PW-1:0]     cnt_q, cnt_d;
   logic              commit_q, commit_d;
   logic [NCH-1:0]    pwm_q;
   logic              wrap, take_commit;

   spi_pwm_slave #(.PW(PW)) u_slave (
      .clk     (clk),
      .reset   (reset),
      .sclk_i  (sclk),
      .cs_n_i  (cs_n),
      .mosi_i  (mosi),
      .rdata_i (rdata),
      .miso_o  (miso),
      .wr_en_o (wr_en),
      .addr_o  (addr),
      .wdata_o (wdata)
   );

   assign wrap        = (cnt_q == act_per_q);
   assign take_commit = wrap & commit_q;

   // A commit request arriving on the same cycle a commit is taken stays
   // pending for the following wrap.
   always_comb begin
      cnt_d    = wrap ? '0 : cnt_q + PW'(1);
      commit_d = (commit_q & ~take_commit) |
                 (wr_en & (addr == ADDR_CTRL) & wdata[0]);
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (addr == ADDR_W'(i)) rdata = shd_lvl_q[i];
      end
      if (addr == ADDR_PERIOD) rdata = shd_per_q;
      if (addr == ADDR_CTRL)   rdata = {{(PW-1){1'b0}}, commit_q};
   end

   // Active registers take the shadow values as they stood before any write
   // landing on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            shd_lvl_q[i] <= '0;
            act_lvl_q[i] <= '0;
         end
         shd_per_q <= PER_RST;
         act_per_q <= PER_RST;
         cnt_q     <= '0;
         commit_q  <= 1'b0;
         pwm_q     <= '0;
      end else begin
         cnt_q    <= cnt_d;
         commit_q <= commit_d;
         if (take_commit) begin
            for (int i = 0; i < NCH; i++) act_lvl_q[i] <= shd_lvl_q[i];
            act_per_q <= shd_per_q;
         end
         for (int i = 0; i < NCH; i++) begin
            if (wr_en && addr == ADDR_W'(i)) shd_lvl_q[i] <= wdata;
            pwm_q[i] <= (cnt_q < act_lvl_q[i]);
         end
         if (wr_en && addr == ADDR_PERIOD) shd_per_q <= wdata;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Self-checking bench for spi_pwm_bank (NCH=8, PW=8) with a register-level
// reference model and duty-cycle measurement of the PWM outputs.
module tb_spi_pwm_bank;

   localparam int NCH  = 8;
   localparam int PW   = 8;
   localparam int HALF = 6;

   logic           clk = 1'b0;
   logic           reset, sclk, cs_n, mosi;
   logic           miso;
   logic [NCH-1:0] pwm_out;

   always #5 clk = ~clk;

   spi_pwm_bank #(.NCH(NCH), .PW(PW)) dut (
      .clk     (clk),
      .reset   (reset),
      .sclk    (sclk),
      .cs_n    (cs_n),
      .mosi    (mosi),
      .miso    (miso),
      .pwm_out (pwm_out)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int m_shd[NCH];
   int m_act[NCH];
   int m_shd_per, m_act_per;
   int m_pend;

   logic [PW-1:0] spi_rd;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_shd[i] = 0;
         m_act[i] = 0;
      end
      m_shd_per = (1 << PW) - 2;
      m_act_per = (1 << PW) - 2;
      m_pend    = 0;
   endfunction

   function automatic int model_read(input int a);
      if (a < NCH) return m_shd[a];
      if (a == 62) return m_shd_per;
      if (a == 63) return m_pend;
      return 0;
   endfunction

   function automatic void model_write(input int a, input int d);
      if (a < NCH)                 m_shd[a]  = d;
      else if (a == 62)            m_shd_per = d;
      else if (a == 63 && (d & 1)) m_pend    = 1;
   endfunction

   task automatic spi_clk_bits(input logic [7+PW:0] bits, input int first, input int last);
      for (int b = first; b <= last; b++) begin
         mosi = bits[7+PW-b];
         repeat (HALF) @(negedge clk);
         if (b >= 8) spi_rd = {spi_rd[PW-2:0], miso};
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_frame(input logic [7:0] cmd, input logic [PW-1:0] wd, input int nbits);
      cs_n   = 1'b0;
      spi_rd = '0;
      repeat (HALF) @(negedge clk);
      spi_clk_bits({cmd, wd}, 0, nbits - 1);
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic wr_reg(input int a, input int d);
      spi_frame({2'b10, 6'(a)}, PW'(d), 8 + PW);
      model_write(a, d);
   endtask

   task automatic rd_chk(input string tag, input int a);
      spi_frame({2'b00, 6'(a)}, '0, 8 + PW);
      check_val(tag, spi_rd, model_read(a));
   endtask

   task automatic do_commit(input string tag);
      int v;
      wr_reg(63, 1);
      v = 1;
      for (int k = 0; k < 4 && v != 0; k++) begin
         spi_frame(8'h3F, '0, 8 + PW);
         v = spi_rd;
      end
      check_val(tag, v, 0);
      for (int i = 0; i < NCH; i++) m_act[i] = m_shd[i];
      m_act_per = m_shd_per;
      m_pend    = 0;
   endtask

   // Any window of whole periods holds min(level, period+1) high cycles per
   // period and, for a level strictly inside the period, one rising edge.
   task automatic measure(input string tag, input int nper);
      int hi[NCH];
      int rise[NCH];
      int len, exp_hi, exp_rise, plen;
      logic [NCH-1:0] prev;
      plen = m_act_per + 1;
      len  = nper * plen;
      for (int i = 0; i < NCH; i++) begin
         hi[i]   = 0;
         rise[i] = 0;
      end
      @(negedge clk);
      prev = pwm_out;
      repeat (len) begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) begin
            if (pwm_out[i]) hi[i]++;
            if (pwm_out[i] && !prev[i]) rise[i]++;
         end
         prev = pwm_out;
      end
      for (int i = 0; i < NCH; i++) begin
         exp_hi   = nper * ((m_act[i] < plen) ? m_act[i] : plen);
         exp_rise = (m_act[i] > 0 && m_act[i] <= m_act_per) ? nper : 0;
         check_val($sformatf("%s_hi_ch%0d", tag, i), hi[i], exp_hi);
         check_val($sformatf("%s_rise_ch%0d", tag, i), rise[i], exp_rise);
      end
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, d;
      reset = 1'b1;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      check_val("rst_pwm", pwm_out, 0);
      check_val("rst_miso", miso, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      rd_chk("rst_period", 62);
      rd_chk("rst_ctrl", 63);
      rd_chk("rst_ch0", 0);

      // Shadow write alone must not reach the outputs
      wr_reg(3, 8'h40);
      measure("nocommit", 3);
      rd_chk("rd_ch3", 3);

      // Commit at wrap, 64 of 255
      do_commit("commit1_clr");
      measure("commit1", 2);
      rd_chk("ctrl_after", 63);

      // Short period, mid/full/zero levels
      wr_reg(62, 9);
      wr_reg(0, 5);
      wr_reg(1, 8'hFF);
      do_commit("commit2_clr");
      measure("per9", 10);

      // Aborted write after 4 data bits
      wr_reg(0, 8'h5A);
      spi_frame(8'h80, 8'hA5, 12);
      check_val("abort_miso", miso, 0);
      rd_chk("abort_ch0", 0);

      // Unmapped address
      rd_chk("unmapped_rd", 8'h20);
      wr_reg(8'h20, 8'hAA);
      for (int i = 0; i < NCH; i++) rd_chk($sformatf("unm_ch%0d", i), i);
      rd_chk("unm_period", 62);
      rd_chk("unm_ctrl", 63);

      // Randomised register traffic followed by a commit
      for (int it = 0; it < 2; it++) begin
         wr_reg(62, $urandom_range(3, 40));
         repeat (10) begin
            if ($urandom_range(0, 3) == 0) a = $urandom_range(NCH, 61);
            else                           a = $urandom_range(0, NCH - 1);
            d = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 45);
            wr_reg(a, d);
         end
         repeat (5) rd_chk("rnd_rd", $urandom_range(0, 63));
         do_commit("rnd_commit_clr");
         measure($sformatf("rnd%0d", it), 3);
      end

      // Reset in the middle of a write frame with a commit pending
      wr_reg(63, 1);
      cs_n   = 1'b0;
      spi_rd = '0;
      repeat (HALF) @(negedge clk);
      spi_clk_bits({8'h80, 8'h77}, 0, 4);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check_val("midrst_pwm", pwm_out, 0);
      check_val("midrst_miso", miso, 0);
      spi_clk_bits({8'h80, 8'h77}, 5, 15);
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (2 * HALF) @(negedge clk);
      rd_chk("midrst_ch0", 0);
      rd_chk("midrst_period", 62);
      rd_chk("midrst_ctrl", 63);
      measure("midrst", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
